// File: rtl/comment_strip_pkg.sv
// Shared types and byte constants for the comment stripper.
package comment_strip_pkg;

  typedef enum logic [2:0] {
    ST_CODE,
    ST_SLASH,
    ST_LINE_CMT,
    ST_BLOCK_CMT,
    ST_BLOCK_STAR,
    ST_STRING,
    ST_STR_ESC
  } state_t;

  localparam logic [7:0] SLASH  = 8'h2F;
  localparam logic [7:0] STAR   = 8'h2A;
  localparam logic [7:0] NL     = 8'h0A;
  localparam logic [7:0] QUOTE  = 8'h22;
  localparam logic [7:0] BSLASH = 8'h5C;
  localparam logic [7:0] SPACE  = 8'h20;

  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  // True when the byte following a '/' opens a comment.
  function automatic logic opens_comment(input logic [7:0] b);
    return (b == SLASH) || (b == STAR);
  endfunction

endpackage

// File: rtl/comment_strip_outreg.sv
// Single-entry output register: holds {data, last} until the consumer takes it.
module comment_strip_outreg (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load,
  input  logic [7:0] i_data,
  input  logic       i_last,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_last,
  output logic       o_can_load
);

  logic       r_valid;
  logic [7:0] r_data;
  logic       r_last;

  // Slot is free when empty or being drained this cycle.
  assign o_can_load = !r_valid || i_ready;

  // Load a new entry, or clear the slot once the consumer takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
      r_last  <= i_last;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_last  = r_last;

endmodule

// File: rtl/comment_strip.sv
// Byte-stream comment remover: drops // and /* */ comments, keeps newlines
// and string literals intact.
//
// state         | meaning
// ST_CODE       | plain source text
// ST_SLASH      | a '/' is held, waiting to see if it opens a comment
// ST_LINE_CMT   | inside a // comment, until newline
// ST_BLOCK_CMT  | inside a /* */ comment
// ST_BLOCK_STAR | inside a block comment, last byte was '*'
// ST_STRING     | inside a string literal
// ST_STR_ESC    | byte after a backslash inside a string
module comment_strip
  import comment_strip_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        err_unterminated,
  output logic [15:0] comment_count
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_count;
  logic        w_can_load;
  logic        w_in_ready;
  logic        w_load;
  logic        w_emit;
  logic [7:0]  w_emit_data;
  logic        w_emit_last;
  logic        w_cnt_inc;
  logic        w_err;

  // Next state, output load and counter/error strobes.
  always_comb begin
    w_next      = r_state;
    w_in_ready  = w_can_load && !reset;
    w_load      = 1'b0;
    w_emit      = 1'b0;
    w_emit_data = in_data;
    w_emit_last = 1'b0;
    w_cnt_inc   = 1'b0;
    w_err       = 1'b0;

    if (r_state == ST_SLASH && in_valid && !opens_comment(in_data)) begin
      // Held '/' was plain text: flush it without consuming the current byte.
      w_in_ready = 1'b0;
      if (w_can_load && !reset) begin
        w_load      = 1'b1;
        w_emit_data = SLASH;
        w_next      = ST_CODE;
      end
    end else if (in_valid && w_in_ready) begin
      case (r_state)
        ST_CODE: begin
          if (in_data == SLASH && !in_last) begin
            w_next = ST_SLASH;
          end else begin
            w_emit = 1'b1;
            if (in_data == QUOTE) w_next = ST_STRING;
          end
        end
        ST_SLASH: begin
          w_cnt_inc = 1'b1;
          w_next    = (in_data == SLASH) ? ST_LINE_CMT : ST_BLOCK_CMT;
        end
        ST_LINE_CMT: begin
          if (in_data == NL) begin
            w_emit = 1'b1;
            w_next = ST_CODE;
          end
        end
        ST_BLOCK_CMT: begin
          if (in_data == NL) w_emit = 1'b1;
          else if (in_data == STAR) w_next = ST_BLOCK_STAR;
        end
        ST_BLOCK_STAR: begin
          if (in_data == SLASH) begin
            w_emit      = 1'b1;
            w_emit_data = SPACE;
            w_next      = ST_CODE;
          end else if (in_data == NL) begin
            w_emit = 1'b1;
            w_next = ST_BLOCK_CMT;
          end else if (in_data != STAR) begin
            w_next = ST_BLOCK_CMT;
          end
        end
        ST_STRING: begin
          w_emit = 1'b1;
          if (in_data == BSLASH) w_next = ST_STR_ESC;
          else if (in_data == QUOTE) w_next = ST_CODE;
        end
        ST_STR_ESC: begin
          w_emit = 1'b1;
          w_next = ST_STRING;
        end
        default: w_next = ST_CODE;
      endcase

      if (in_last) begin
        // Frame end always yields one output byte so the frame boundary survives.
        w_next      = ST_CODE;
        w_load      = 1'b1;
        w_emit_last = 1'b1;
        if (!w_emit) w_emit_data = SPACE;
        case (r_state)
          ST_BLOCK_CMT:  w_err = 1'b1;
          ST_BLOCK_STAR: w_err = (in_data != SLASH);
          ST_STRING:     w_err = (in_data != QUOTE);
          ST_STR_ESC:    w_err = 1'b1;
          default:       w_err = 1'b0;
        endcase
      end else begin
        w_load = w_emit;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_CODE;
    else       r_state <= w_next;
  end

  // Saturating count of comments opened.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               r_count <= 16'h0000;
    else if (w_cnt_inc && r_count != COUNT_MAX) r_count <= r_count + 16'd1;
  end

  comment_strip_outreg u_outreg (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_data     (w_emit_data),
    .i_last     (w_emit_last),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_data     (out_data),
    .o_last     (out_last),
    .o_can_load (w_can_load)
  );

  assign in_ready         = w_in_ready;
  assign err_unterminated = w_err;
  assign comment_count    = r_count;

endmodule

// File: doc/comment_strip.md
# comment_strip

Byte-stream comment remover: the front stage of the hardware Verilog source pipeline. It accepts raw source text one byte per beat and forwards it with `//` and `/* */` comments removed. Line structure is preserved, and string literals pass through untouched. Its output feeds the tokenizer directly, so downstream stages never see comment text.

## Interface
- No parameters.
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  input byte valid
- in_ready  out  1  input byte accepted when in_valid && in_ready (combinational)
- in_data  in  8  ASCII byte
- in_last  in  1  byte is final byte of a source file (frame)
- out_valid  out  1  output byte valid (registered)
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  8  stripped ASCII byte (registered)
- out_last  out  1  final byte of frame (registered)
- err_unterminated  out  1  one-cycle pulse: frame ended inside block comment or string
- comment_count  out  16  comments removed since reset, saturating at 0xFFFF

## Operation
- States: CODE, SLASH (a '/' is pending), LINE_CMT, BLOCK_CMT, BLOCK_STAR (a '*' was seen inside a block comment), STRING, STR_ESC.
- CODE:
  - '/' (not last): consume, emit nothing, go to SLASH.
  - '"': emit, go to STRING.
  - Any other byte: emit.
  - '/' with in_last: emit '/' with out_last.
- SLASH:
  - '/': consume, go to LINE_CMT, count++.
  - '*': consume, go to BLOCK_CMT, count++.
  - Any other byte: emit the held '/' without consuming (in_ready=0 this beat), go to CODE; that byte is handled next beat in CODE.
- LINE_CMT: swallow bytes; on 0x0A, emit 0x0A and go to CODE.
- BLOCK_CMT: swallow bytes, except emit each 0x0A. On '*', go to BLOCK_STAR.
- BLOCK_STAR:
  - '/': emit 0x20, go to CODE.
  - '*': stay.
  - 0x0A: emit it, go to BLOCK_CMT.
  - Else: go to BLOCK_CMT.
- STRING: emit every byte. '\\' goes to STR_ESC; '"' goes to CODE.
- STR_ESC: emit the byte, go to STRING (so `\"` does not close the string).
- Frame end, applies in every state when the in_last byte is consumed:
  - The next state is CODE.
  - If that byte produces an output, that output carries out_last=1.
  - If the byte is swallowed, emit 0x20 with out_last=1.
  - If the state before that byte was BLOCK_CMT, BLOCK_STAR, STRING or STR_ESC, and the byte does not itself close the construct, pulse err_unterminated in the same cycle the byte is consumed.
- Case: "a/*x" + last
  - Output: 'a', then 0x20 with out_last=1.
  - err_unterminated pulses once.
- Case: "//" at end of frame → 0x20 with out_last=1; no error.
- comment_count:
  - Increments on the beat where the second comment-opening character is consumed.
  - Holds at 0xFFFF.
  - Is not cleared at frame end.

## Timing
- Reset values: out_valid=0, out_data=0x00, out_last=0, err_unterminated=0, comment_count=0, state=CODE.
- Reset mid-frame: the partial frame is discarded and no out_last is produced; in_ready reads 0 while reset is asserted.
- Latency:
  - Emitted byte: appears on out_data 1 cycle after acceptance.
  - '/' followed by a non-comment byte: appears 1 cycle after that byte is presented.
- Output register is a single entry. Base rule: in_ready = !out_valid || out_ready, forced to 0 in the SLASH non-comment case.
- Full throughput (1 byte/cycle) with out_ready held at 1, except one bubble per non-comment '/'.
- Backpressure: out_data/out_last stay stable while out_valid && !out_ready; no byte is lost or duplicated.
- A swallowed byte with in_last=1 still needs a free output slot (it emits 0x20), so it is accepted only when that slot is free.

## Structure
- Package comment_strip_pkg holds:
  - state enum (7 states);
  - byte constants: SLASH 0x2F, STAR 0x2A, NL 0x0A, QUOTE 0x22, BSLASH 0x5C, SPACE 0x20.
- One sub-module, comment_strip_outreg: single-entry valid/ready register carrying {data, last}, with a load strobe and a can-load output.
- The FSM and counter live in comment_strip.

## Test plan
- "a//b\nc" + last on 'c', out_ready=1 → 'a', 0x0A, 'c'(last); comment_count=1; no error.
- "x/*1\n2*/y" + last on 'y' → 'x', 0x0A, 0x20, 'y'(last); comment_count=1.
- "p/q" → 'p', '/', 'q'; in_ready low exactly one cycle while 'q' is presented.
- "\"a//b\\\"c\"" (string with `//` and an escaped quote) → passes through byte-identical; comment_count=0.
- "a/*x" + last → 'a', 0x20(last); err_unterminated one-cycle pulse; the next frame "z"(last) → 'z'(last).
- Random out_ready toggling plus reset asserted mid-block-comment:
  - Output matches the reference model byte for byte.
  - After reset: out_valid=0 and comment_count=0, and the next frame strips correctly.
